// File: rtl/mod_n_counter.sv
// Modulo-N up/down counter with enable, cascade tc and registered wrap pulse.
// Define MOD_N_COUNTER_LOAD_EN to enable the clamped parallel load.
module mod_n_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic             wrap_q;
  logic             wrap_d;
  logic             at_max;
  logic             at_zero;
  logic             step;

  assign at_max  = (cnt_q == MAX);
  assign at_zero = (cnt_q == '0);

`ifdef MOD_N_COUNTER_LOAD_EN
  assign step = en & ~load;
`else
  logic unused_load;
  assign unused_load = ^{load, d};
  assign step = en;
`endif

  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
`ifdef MOD_N_COUNTER_LOAD_EN
    // out-of-range load saturates so q stays inside 0..MODULUS-1
    if (load) begin
      cnt_d = (d > MAX) ? MAX : d;
    end
`endif
    if (step) begin
      if (up) begin
        cnt_d  = at_max ? '0 : cnt_q + WIDTH'(1);
        wrap_d = at_max;
      end else begin
        cnt_d  = at_zero ? MAX : cnt_q - WIDTH'(1);
        wrap_d = at_zero;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  assign q    = cnt_q;
  assign wrap = wrap_q;
  assign tc   = en & ((up & at_max) | (~up & at_zero));

endmodule

// File: doc/mod_n_counter.md
# mod_n_counter

Parametrised synchronous modulo-N counter with up/down direction, count enable, parallel load, and cascade/terminal-count outputs. It is the general-purpose successor to the team's fixed 4-bit T-flip-flop modulo-14 counter. It is used wherever a divide-by-N, sequencer index, or cascadable BCD/modulo stage is needed. It is a single clock domain block.

## Interface

Parameters:
- WIDTH, default 4: counter width in bits; must be at least 1.
- MODULUS, default 14: count range 0..MODULUS-1; legal range is 2 ≤ MODULUS ≤ 2^WIDTH.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  count enable; when high, q advances one step per clock.
- up  in  1  direction; 1 = increment, 0 = decrement.
- load  in  1  parallel load request.
- d  in  WIDTH  parallel load value.
- q  out  WIDTH  current count.
- tc  out  1  terminal count / cascade carry; combinational.
- wrap  out  1  registered one-cycle pulse; high in the cycle after q wrapped around.

## Operation

- Each rising edge of clk applies the following priority:
  - reset = 1: q ← 0 and wrap ← 0.
  - else load = 1: q ← d if d < MODULUS, otherwise q ← MODULUS-1 (saturating clamp). wrap ← 0. en and up are ignored.
  - else en = 1 and up = 1: q ← (q == MODULUS-1) ? 0 : q+1.
  - else en = 1 and up = 0: q ← (q == 0) ? MODULUS-1 : q-1.
  - else: q holds and wrap ← 0.
- wrap ← 1 only on an enabled step that crosses the boundary:
  - up: MODULUS-1 → 0.
  - down: 0 → MODULUS-1.
- tc = en & ((up & q == MODULUS-1) | (~up & q == 0)).
- Cascading: connect a lower stage's tc to the next stage's en, and share up between stages. A higher stage then steps exactly once per lower-stage wrap.
- Changing direction mid-count takes effect on the same edge that samples the new up value. There is no extra state.
- Comparisons are done at WIDTH bits; no intermediate value exceeds WIDTH bits. When MODULUS == 2^WIDTH, wrapping is natural overflow and must produce identical results.
- q never leaves the range 0..MODULUS-1 after reset, including after a load.

## Timing

- Reset values: q = 0, wrap = 0. tc follows from en, up and q (0 when en = 0).
- q has 1-cycle latency from the en, load or d sample to the new value.
- wrap is high for exactly one cycle: the cycle in which q shows the wrapped value (0 for up, MODULUS-1 for down).
- tc is combinational with no register. It is valid in the same cycle as q, en and up.
- reset asserted mid-count clears state on that edge. Counting resumes on the first edge with reset = 0 and en = 1.
- load and reset together: reset wins.
- load and en together: load wins, and that cycle produces no step.

## Configuration

- Macro: MOD_N_COUNTER_LOAD_EN.
- Defined: parallel load behaves as described above, including the clamp.
- Not defined:
  - load and d remain in the port list but are ignored.
  - No load logic or clamp comparator is synthesised.
  - The priority becomes reset > en.

## Test plan

- WIDTH = 4, MODULUS = 14, reset then en = 1, up = 1 for 15 cycles:
  - q steps 0, 1, …, 13, 0, 1.
  - tc = 1 only while q = 13.
  - wrap = 1 only in the cycle with q = 0 after 13.
- From reset, en = 1, up = 0:
  - q steps 0 → 13 → 12.
  - tc = 1 while q = 0.
  - wrap pulses with q = 13.
- With MOD_N_COUNTER_LOAD_EN defined:
  - load = 1, d = 9, en = 1 → q = 9 next cycle (no increment), wrap = 0.
  - load = 1, d = 15 → q = 13.
  - Without the macro, the same stimulus counts normally.
- Counting at q = 7, assert reset together with load = 1 and en = 1 → q = 0 and wrap = 0 next cycle. Then en = 1 → q = 1.
- en = 0 for 5 cycles at q = 13, up = 1 → q holds at 13, tc = 0, wrap = 0. Set en = 1 → q = 0 with a wrap pulse.
- Two instances, WIDTH = 4, MODULUS = 10, cascaded (low tc → high en), up = 1, 100 enabled cycles from reset:
  - high:low reads 9:9 after 99 cycles.
  - Reads 0:0 after 100 cycles, with both wrap outputs pulsing together.
